// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand/opcode widths and the defined opcode encodings.
// The ALU itself imports the same package, so opcode values live only here.
package alu_pkg;

  localparam int NB_DATA = 4;
  localparam int NB_OP   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  localparam int NUM_OPS = 8;
  localparam logic [5:0] OP_LIST [NUM_OPS] = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
                                               OP_XOR, OP_SRA, OP_SRL, OP_NOR};

endpackage

// File: rtl/alu_input_loader_if.sv
// Board-side bundle of the ALU input loader: switch bus and buttons in, ALU operands and LED status out.
// master = board/stimulus side, slave = the loader.
interface alu_input_loader_if import alu_pkg::*; #(
  parameter int NB_DATA = alu_pkg::NB_DATA,
  parameter int NB_OP   = alu_pkg::NB_OP,
  parameter int NB_SW   = 8
);

  logic [NB_SW-1:0]   i_sw;
  logic               i_btn_a;
  logic               i_btn_b;
  logic               i_btn_op;
  logic [NB_DATA-1:0] o_datoA;
  logic [NB_DATA-1:0] o_datoB;
  logic [NB_OP-1:0]   o_operation;
  logic [2:0]         o_loaded;
  logic               o_ready;
  logic               o_valid;
  logic               o_op_err;

  modport master (
    output i_sw, i_btn_a, i_btn_b, i_btn_op,
    input  o_datoA, o_datoB, o_operation, o_loaded, o_ready, o_valid, o_op_err
  );

  modport slave (
    input  i_sw, i_btn_a, i_btn_b, i_btn_op,
    output o_datoA, o_datoB, o_operation, o_loaded, o_ready, o_valid, o_op_err
  );

endinterface

// File: rtl/button_debouncer.sv
// Raw push-button to single-cycle press pulse: 2-FF sync, N-cycle debounce, registered rising-edge detect.
// A raw rise set up before edge k produces o_press in the cycle after edge k+N+2.
module button_debouncer #(
  parameter int N = 1000000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(N);

  logic          sync1;
  logic          s;
  logic          db;
  logic          db_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1   <= 1'b0;
      s       <= 1'b0;
      db      <= 1'b0;
      db_d    <= 1'b0;
      cnt     <= '0;
      o_press <= 1'b0;
    end else begin
      sync1   <= i_btn;
      s       <= sync1;
      db_d    <= db;
      o_press <= db & ~db_d;
      // cnt holds the length of the current run of s disagreeing with the accepted level
      if (s == db) begin
        cnt <= '0;
      end else if (cnt == CW'(N - 1)) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_input_loader.sv
// Latches the switch bus into ALU operand A/B and opcode registers on debounced button presses.
// Load lands N+3 edges after a raw press; o_valid follows one cycle later when all three are loaded.
module alu_input_loader #(
  parameter int NB_DATA         = alu_pkg::NB_DATA,
  parameter int NB_OP           = alu_pkg::NB_OP,
  parameter int NB_SW           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic              clk,
  input logic              i_rst_n,
  alu_input_loader_if.slave bus
);

  import alu_pkg::*;

  logic [2:0]         press;
  logic [NB_DATA-1:0] dato_a;
  logic [NB_DATA-1:0] dato_b;
  logic [NB_OP-1:0]   operation;
  logic [2:0]         loaded;
  logic               valid;
  logic               op_err;
  logic               unused_sw;

  button_debouncer #(.N(DEBOUNCE_CYCLES)) u_db_a (
    .clk(clk), .i_rst_n(i_rst_n), .i_btn(bus.i_btn_a), .o_press(press[0])
  );

  button_debouncer #(.N(DEBOUNCE_CYCLES)) u_db_b (
    .clk(clk), .i_rst_n(i_rst_n), .i_btn(bus.i_btn_b), .o_press(press[1])
  );

  button_debouncer #(.N(DEBOUNCE_CYCLES)) u_db_op (
    .clk(clk), .i_rst_n(i_rst_n), .i_btn(bus.i_btn_op), .o_press(press[2])
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dato_a    <= '0;
      dato_b    <= '0;
      operation <= '0;
      loaded    <= 3'b000;
      valid     <= 1'b0;
    end else begin
      if (press[0]) dato_a    <= bus.i_sw[NB_DATA-1:0];
      if (press[1]) dato_b    <= bus.i_sw[NB_DATA-1:0];
      if (press[2]) operation <= bus.i_sw[NB_OP-1:0];
      loaded <= loaded | press;
      // judged on the flags as they stand after this load, so the completing load counts
      valid  <= (|press) && ((loaded | press) == 3'b111);
    end
  end

  always_comb begin
    op_err = 1'b1;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (operation == NB_OP'(OP_LIST[i])) op_err = 1'b0;
    end
  end

  // switch bits above the widest register are intentionally ignored
  assign unused_sw = ^bus.i_sw;

  assign bus.o_datoA     = dato_a;
  assign bus.o_datoB     = dato_b;
  assign bus.o_operation = operation;
  assign bus.o_loaded    = loaded;
  assign bus.o_ready     = &loaded;
  assign bus.o_valid     = valid;
  assign bus.o_op_err    = op_err;

endmodule

// File: tb/tb_alu_input_loader.sv
// Bench for alu_input_loader with a short debounce window; directed scenarios then random button traffic.
module tb_alu_input_loader;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_input_loader_if bus ();

  alu_input_loader #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  // Reference model: a button's accepted level flips once the last N raw samples all disagree with it;
  // a flip to 1 schedules a load 4 edges later (2 sync stages + edge detect + load register).
  logic [N-1:0] hist [3];
  logic         acc [3];
  int           load_edge [3];
  int           edge_no;
  logic [3:0]   m_a, m_b;
  logic [5:0]   m_op;
  logic [2:0]   m_loaded;
  logic         m_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_op_err(input logic [5:0] v);
    return !(v inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                       6'b100110, 6'b000011, 6'b000010, 6'b100111});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i]      = '0;
      acc[i]       = 1'b0;
      load_edge[i] = -1;
    end
    edge_no  = 0;
    m_a      = '0;
    m_b      = '0;
    m_op     = '0;
    m_loaded = '0;
    m_valid  = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] btn;
    logic [2:0] fired;
    logic [7:0] sw;
    btn   = {bus.i_btn_op, bus.i_btn_b, bus.i_btn_a};
    sw    = bus.i_sw;
    fired = '0;
    edge_no++;
    for (int i = 0; i < 3; i++) begin
      if (load_edge[i] == edge_no) begin
        fired[i]     = 1'b1;
        load_edge[i] = -1;
      end
    end
    if (fired[0]) m_a  = sw[3:0];
    if (fired[1]) m_b  = sw[3:0];
    if (fired[2]) m_op = sw[5:0];
    m_loaded = m_loaded | fired;
    m_valid  = (fired != 0) && (m_loaded == 3'b111);
    for (int i = 0; i < 3; i++) begin
      hist[i] = {hist[i][N-2:0], btn[i]};
      if (acc[i] ? (hist[i] == '0) : (hist[i] == '1)) begin
        acc[i] = ~acc[i];
        if (acc[i]) load_edge[i] = edge_no + 4;
      end
    end
  endtask

  task automatic check_all();
    chk("datoA",     bus.o_datoA,     m_a);
    chk("datoB",     bus.o_datoB,     m_b);
    chk("operation", bus.o_operation, m_op);
    chk("loaded",    bus.o_loaded,    m_loaded);
    chk("ready",     bus.o_ready,     &m_loaded);
    chk("valid",     bus.o_valid,     m_valid);
    chk("op_err",    bus.o_op_err,    exp_op_err(m_op));
  endtask

  // Inputs are only changed after this returns, so the model sees exactly what the edge sampled.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else        model_step();
    check_all();
  endtask

  task automatic set_btns(input logic [2:0] m);
    bus.i_btn_a  = m[0];
    bus.i_btn_b  = m[1];
    bus.i_btn_op = m[2];
  endtask

  task automatic hold_btns(input logic [2:0] m, input int cyc, input int gap);
    set_btns(m);
    repeat (cyc) tick();
    set_btns(3'b000);
    repeat (gap) tick();
  endtask

  task automatic async_reset(input int hold);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    repeat (hold) tick();
    rst_n = 1'b1;
  endtask

  int lat;
  int pulses;
  int run_left [3];
  logic [2:0] lvl;

  initial begin
    bus.i_sw = '0;
    set_btns(3'b000);
    model_reset();

    // reset state
    repeat (3) tick();
    chk("rst_op_err", bus.o_op_err, 1'b1);
    rst_n = 1'b1;
    repeat (2) tick();

    // load A; latency measured from the first edge seeing the raw press
    bus.i_sw = 8'h05;
    set_btns(3'b001);
    lat = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (t == 9) set_btns(3'b000);
      if (lat < 0 && bus.o_datoA == 4'h5) lat = t;
    end
    chk("lat_a", lat, N + 3);
    chk("loaded_a", bus.o_loaded, 3'b001);

    // B glitch shorter than N is ignored, then a clean press
    bus.i_sw = 8'h03;
    hold_btns(3'b010, N - 1, 12);
    chk("glitch_b", bus.o_loaded, 3'b001);
    hold_btns(3'b010, 8, 12);
    chk("dato_b", bus.o_datoB, 4'h3);

    // opcode completes the set; then an undefined opcode
    bus.i_sw = 8'h20;
    pulses = 0;
    set_btns(3'b100);
    for (int t = 0; t < 20; t++) begin
      tick();
      if (t == 7) set_btns(3'b000);
      if (bus.o_valid) pulses++;
    end
    chk("op_add_pulses", pulses, 1);
    chk("op_add_err", bus.o_op_err, 1'b0);
    bus.i_sw = 8'h3F;
    hold_btns(3'b100, 8, 12);
    chk("op_3f_err", bus.o_op_err, 1'b1);

    // simultaneous A+B held long: one load each, one valid pulse
    bus.i_sw = 8'h0A;
    pulses = 0;
    set_btns(3'b011);
    for (int t = 0; t < 60; t++) begin
      tick();
      if (t == 49) set_btns(3'b000);
      if (bus.o_valid) pulses++;
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_ab", {bus.o_datoA, bus.o_datoB}, 8'hAA);

    // reset mid-debounce with A held through reset release
    bus.i_sw = 8'h09;
    set_btns(3'b001);
    repeat (4) tick();
    async_reset(2);
    lat = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (lat < 0 && bus.o_datoA == 4'h9) lat = t;
    end
    chk("lat_after_rst", lat, N + 3);
    hold_btns(3'b000, 0, 10);

    // random button traffic with switches changing every cycle
    for (int i = 0; i < 3; i++) run_left[i] = 0;
    lvl = '0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (run_left[i] == 0) begin
          lvl[i]      = 1'($urandom_range(0, 1));
          run_left[i] = int'($urandom_range(1, 2 * N + 3));
        end
        run_left[i]--;
      end
      set_btns(lvl);
      bus.i_sw = 8'($urandom);
      if ($urandom_range(0, 399) == 0) async_reset(int'($urandom_range(1, 3)));
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
